// File: rtl/mem_copy_if.sv
// Control and memory-port bundle for the copy engine. The engine connects
// through the slave modport; the controller/memory side uses master.
interface mem_copy_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] src_address;
    logic [ADDR_WIDTH-1:0] dst_address;
    logic [ADDR_WIDTH-1:0] length;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] words_copied;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_output;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_data_input;

    modport master (
        output start, abort, src_address, dst_address, length, mem_data_input,
        input  busy, done, words_copied, mem_address, mem_data_output, mem_write_enable
    );

    modport slave (
        input  start, abort, src_address, dst_address, length, mem_data_input,
        output busy, done, words_copied, mem_address, mem_data_output, mem_write_enable
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one READ and one WRITE cycle per word,
// ascending addresses with silent wrap, abortable, single-cycle done pulse.
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    mem_copy_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] count;
    logic                  accept;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  write_enable;

    // count is both the word index i and the words_copied value
    assign accept    = bus.start && !bus.abort;
    assign last_word = (count + ONE) == len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        src   <= bus.src_address;
                        dst   <= bus.dst_address;
                        len   <= bus.length;
                        count <= '0;
                    end
                end
                // the write in flight completes even under abort, so it is counted
                WRITE:   count <= count + ONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.length == '0) ? DONE : READ;
                end
            end
            READ:    state_next = bus.abort ? IDLE : WRITE;
            WRITE: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = last_word ? DONE : READ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        address      = '0;
        data_out     = '0;
        write_enable = 1'b0;
        case (state)
            READ: begin
                address = src + count;
            end
            WRITE: begin
                address      = dst + count;
                data_out     = bus.mem_data_input;
                write_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy             = (state == READ) || (state == WRITE);
    assign bus.done             = (state == DONE);
    assign bus.words_copied     = count;
    assign bus.mem_address      = address;
    assign bus.mem_data_output  = data_out;
    assign bus.mem_write_enable = write_enable;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a registered-read data memory model
// and an 8-bit address space so wrap-around is reachable.
module tb_mem_copy_engine;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_copy_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // data_memory: registered read, read data held during a write cycle
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rdata;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (bus.mem_write_enable)
            mem[bus.mem_address] <= bus.mem_data_output;
        else
            rdata <= mem[bus.mem_address];
    end
    assign bus.mem_data_input = rdata;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] n);
        bus.src_address = s;
        bus.dst_address = d;
        bus.length      = n;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    logic [DW-1:0] basic_words [0:2];
    logic [DW-1:0] wrap_words  [0:2];

    initial begin
        basic_words = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
        wrap_words  = '{16'h1111, 16'h2222, 16'h3333};
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.src_address = '0;
        bus.dst_address = '0;
        bus.length      = '0;
        pre_we          = 1'b0;
        pre_addr        = '0;
        pre_data        = '0;

        step();
        step();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_wc",   bus.words_copied, 0);
        check("rst_we",   bus.mem_write_enable, 0);
        check("rst_addr", bus.mem_address, 0);
        check("rst_dout", bus.mem_data_output, 0);
        reset_n = 1'b1;

        for (int k = 0; k < 5; k++) poke(8'(8'h10 + k), 16'h0100 + 16'(k));
        for (int k = 0; k < 3; k++) poke(8'(8'h10 + k), basic_words[k]);
        for (int k = 0; k < 3; k++) poke(8'(8'h20 + k), 16'h5555);
        poke(8'h90, 16'h5555);
        for (int k = 0; k < 3; k++) poke(8'(8'hFE + k), wrap_words[k]);
        for (int k = 0; k < 4; k++) poke(8'(8'h60 + k), 16'h5555);
        poke(8'h70, 16'h5555);
        step();

        // basic copy with a start pulse injected mid-copy that must be ignored
        launch(8'h10, 8'h20, 8'd3);
        for (int c = 1; c <= 6; c++) begin
            check("basic_busy", bus.busy, 1);
            check("basic_done", bus.done, 0);
            check("basic_we",   bus.mem_write_enable, (c % 2 == 0) ? 1 : 0);
            if (c % 2 == 1)
                check("basic_raddr", bus.mem_address, 32'h10 + (c - 1) / 2);
            else begin
                check("basic_waddr", bus.mem_address, 32'h20 + (c - 2) / 2);
                check("basic_wdata", bus.mem_data_output, basic_words[(c - 2) / 2]);
            end
            if (c == 3) begin
                bus.src_address = 8'h80;
                bus.dst_address = 8'h90;
                bus.length      = 8'd1;
                bus.start       = 1'b1;
            end
            step();
            bus.start = 1'b0;
        end
        check("basic_done7", bus.done, 1);
        check("basic_busy7", bus.busy, 0);
        check("basic_wc",    bus.words_copied, 3);
        check("basic_we7",   bus.mem_write_enable, 0);
        check("basic_addr7", bus.mem_address, 0);
        step();
        check("basic_done8", bus.done, 0);
        check("basic_busy8", bus.busy, 0);
        step();
        check("ignored_busy9", bus.busy, 0);
        for (int k = 0; k < 3; k++) check("basic_mem", mem[8'h20 + k], basic_words[k]);
        check("ignored_dst", mem[8'h90], 16'h5555);

        // zero length: done in cycle 1, no memory access, count cleared
        launch(8'h10, 8'h30, 8'd0);
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 0);
        check("zero_we",   bus.mem_write_enable, 0);
        check("zero_wc",   bus.words_copied, 0);
        step();
        check("zero_done2", bus.done, 0);
        check("zero_busy2", bus.busy, 0);

        // wrap-around of the source address
        launch(8'hFE, 8'h40, 8'd3);
        for (int c = 1; c <= 6; c++) begin
            if (c % 2 == 1)
                check("wrap_raddr", bus.mem_address, 32'((8'hFE + (c - 1) / 2) % 256));
            else
                check("wrap_waddr", bus.mem_address, 32'h40 + (c - 2) / 2);
            step();
        end
        check("wrap_done", bus.done, 1);
        for (int k = 0; k < 3; k++) check("wrap_mem", mem[8'h40 + k], wrap_words[k]);
        step();

        // abort during the third WRITE (cycle 6)
        launch(8'h10, 8'h60, 8'd5);
        for (int c = 1; c <= 5; c++) step();
        check("abort_we6", bus.mem_write_enable, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_we",   bus.mem_write_enable, 0);
        check("abort_wc",   bus.words_copied, 3);
        step();
        check("abort_done2", bus.done, 0);
        check("abort_busy2", bus.busy, 0);
        check("abort_wc2",   bus.words_copied, 3);
        for (int k = 0; k < 3; k++) check("abort_mem", mem[8'h60 + k], basic_words[k]);
        check("abort_untouched", mem[8'h63], 16'h5555);

        // abort beats start in IDLE
        bus.abort = 1'b1;
        launch(8'h10, 8'h60, 8'd2);
        bus.abort = 1'b0;
        check("prio_busy", bus.busy, 0);
        check("prio_done", bus.done, 0);
        step();

        // asynchronous reset in the middle of the first WRITE
        launch(8'h10, 8'h70, 8'd3);
        step();
        check("rstmid_we_pre", bus.mem_write_enable, 1);
        reset_n = 1'b0;
        #1;
        check("rstmid_we",   bus.mem_write_enable, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_done", bus.done, 0);
        check("rstmid_wc",   bus.words_copied, 0);
        check("rstmid_addr", bus.mem_address, 0);
        check("rstmid_dout", bus.mem_data_output, 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        check("rstmid_busy_after", bus.busy, 0);
        check("rstmid_mem", mem[8'h70], 16'h5555);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a copy; sampled only in IDLE.
REQ-007 abort  input  1  cancel the copy in progress.
REQ-008 src_address  input  ADDR_WIDTH  first source word address.
REQ-009 dst_address  input  ADDR_WIDTH  first destination word address.
REQ-010 length  input  ADDR_WIDTH  number of words to copy.
REQ-011 busy  output  1  high in READ and WRITE.
REQ-012 done  output  1  high for exactly one cycle, in DONE only.
REQ-013 words_copied  output  ADDR_WIDTH  count of words written in the current or last copy.
REQ-014 mem_address  output  ADDR_WIDTH  to data_memory address.
REQ-015 mem_data_output  output  DATA_WIDTH  to data_memory data_input.
REQ-016 mem_write_enable  output  1  to data_memory write_enable.
REQ-017 mem_data_input  input  DATA_WIDTH  from data_memory data_output.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-019 In IDLE, start=1 SHALL latch src_address, dst_address and length, and SHALL clear words_copied.
- If length=0, next state SHALL be DONE, with no memory access.
- Otherwise, next state SHALL be READ.
REQ-020 The memory port SHALL assume data_memory timing: read data is registered, valid the cycle after the address is presented with write_enable=0, and held while write_enable=1.
REQ-021 READ (one cycle) SHALL drive:
- mem_address = latched src + i
- mem_write_enable = 0
- then go to WRITE.
REQ-022 WRITE (one cycle) SHALL drive:
- mem_address = latched dst + i
- mem_write_enable = 1
- mem_data_output = mem_data_input
- at cycle end: i and words_copied increment.
- next state: DONE if i+1 = length, else READ.
REQ-023 Throughput SHALL be 2 cycles per word; done SHALL be high in the (2N+1)th cycle after the start-sampling edge for N>0, and in the 1st cycle for N=0.
REQ-024 DONE SHALL last one cycle, then go to IDLE; start SHALL be ignored in DONE, READ and WRITE.
REQ-025 Address arithmetic SHALL be modulo 2^ADDR_WIDTH, and addresses SHALL wrap silently.
REQ-026 Copy order SHALL be ascending, with no overlap protection; overlapping regions give a defined forward-copy result.
REQ-027 abort=1 in READ or WRITE SHALL force IDLE at the next edge.
- No done pulse.
- A WRITE cycle in progress still completes its write, and words_copied counts it.
- words_copied holds its value afterwards.
REQ-028 abort SHALL have priority over start.
REQ-029 In IDLE and DONE, the block SHALL drive mem_write_enable=0, mem_address=0 and mem_data_output=0.
REQ-030 mem_write_enable SHALL never be high outside WRITE.

Reset
REQ-031 reset_n=0 SHALL asynchronously force:
- state IDLE
- busy=0, done=0, words_copied=0
- mem_write_enable=0, mem_address=0, mem_data_output=0
- latched registers=0
REQ-032 Reset mid-copy SHALL drop mem_write_enable immediately, with no further writes; operation resumes only on a new start after reset_n=1.

Verification
REQ-033 Bench SHALL connect the DUT to data_memory and cover the following scenarios.
- Reset: assert reset_n=0 mid-WRITE -> mem_write_enable=0 within the same cycle; all outputs 0; destination word not written after release.
- Basic copy: memory[0x10..0x12]=0xA1B2,0xC3D4,0xE5F6; start with src=0x10, dst=0x20, length=3 -> memory[0x20..0x22] equals those values; done in cycle 7; words_copied=3; busy high for cycles 1-6.
- Zero length: start with length=0 -> done in cycle 1; busy never high; mem_write_enable never high; words_copied=0.
- Wrap-around: with ADDR_WIDTH=8, src=0xFE, dst=0x40, length=3 -> reads 0xFE, 0xFF, 0x00; writes 0x40-0x42.
- Abort: length=5; abort during the 3rd WRITE -> 3 words written; no done; IDLE next cycle; words_copied=3; memory[dst+3] unchanged.
- Ignored start: start pulsed with new addresses during busy -> the ongoing copy is unaffected; no second copy.
